alu: RTL and testbench
======================

# alu

Two-stage pipelined integer execution unit sitting directly downstream of the reservation station. It accepts one dispatched RV32I non-memory operation per cycle (opcode 0 = bubble) and computes the result, branch outcome and jump target. It broadcasts the result on the ALU result bus two cycles later, where the reservation station, load/store buffer and ROB pick it up. It never back-pressures: a full pipeline is always able to accept a new operation.

## Interface
Parameters:
- ROB_W, 6: ROB index width
- XLEN, 32: datapath width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- rdy  in  1  global enable; low freezes all state
- flush  in  1  misprediction flush from CDB, synchronous, qualified by rdy
- alu_opcode  in  6  dispatched op; 0 = bubble
- alu_val1, alu_val2  in  XLEN  rs1/rs2 values
- alu_imm  in  XLEN  sign-extended immediate
- alu_pc  in  XLEN  instruction PC
- alu_rob_index  in  ROB_W  destination ROB tag
- alu_valid  out  1  result valid this cycle
- alu_res  out  XLEN  result (rd value; branch: 1 = taken)
- alu_rob_index_out  out  ROB_W  tag of alu_res
- alu_jump  out  1  control transfer taken (taken branch, JAL, JALR)
- alu_target  out  XLEN  target PC when alu_jump

## Operation
- Opcode map (shared package): 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5–10 BEQ/BNE/BLT/BGE/BLTU/BGEU, 11–18 loads/stores (never routed here; treated as bubble), 19–27 ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, 28–37 ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND. Opcodes 11–18 and >37 are bubbles.
- Stage E1: register valid, opcode, ROB tag, operand A, and operand B.
  - A = pc for AUIPC/JAL/branches' target, val1 otherwise.
  - B = imm for I-type/LUI/AUIPC, val2 for R-type/branches.
  - Also register target: pc+imm for JAL/branches; (val1+imm)&~1 for JALR.
- Stage E2: compute the result and drive the output registers.
  - LUI: res = imm. AUIPC: res = pc+imm.
  - JAL/JALR: res = pc+4, jump = 1.
  - Branches: res = {31'b0, taken}, jump = taken.
  - Shifts use B[4:0] only. Arithmetic wraps modulo 2^32. SLT/SLTI signed; SLTU/SLTIU unsigned.
- Outputs are registered. When not valid, alu_res, alu_jump and alu_target are 0.

## Timing
- Reset (rst_n low, any time, async): all stage regs and outputs 0, alu_valid = 0. A reset mid-operation discards in-flight ops.
- Latency: an op sampled at edge k is visible on the outputs after edge k+2 for exactly one cycle. Throughput is 1 op/cycle; back-to-back ops produce back-to-back valids.
- Bubbles propagate as alu_valid = 0 with zeroed payload.
- flush with rdy high at edge k: E1 and output regs are cleared, so alu_valid = 0 after k. Any op presented at k is dropped. No result from pre-flush ops appears after k.
- rdy low: every register holds, including outputs. alu_valid stays asserted if it was; consumers are also rdy-gated. flush is ignored while rdy is low.
- flush and reset together: reset wins.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams (OP_NOP … OP_AND)
  - class helpers: is_branch, is_imm_type, is_lsb_op
  - ROB_W and XLEN defaults, shared with the reservation station and ROB
- One natural sub-module: `alu_core`, a pure combinational function (opcode, A, B, pc) → (res, jump), instantiated in E2. The pipeline registers and flush/rdy control stay in `alu`.

## Test plan
- Reset and bubble: hold rst_n low, release, then drive opcode 0 for 5 cycles → alu_valid = 0, all outputs 0.
- ADD then SUB back-to-back: val1 = 7, val2 = 5, tags 3 and 4 → after k+2, res = 12 with tag 3; next cycle res = 2 with tag 4. SUB with val1 = 0, val2 = 1 → res = 0xFFFFFFFF.
- BLT vs BLTU: val1 = 0xFFFFFFFF, val2 = 1, pc = 0x100, imm = 0x20 → BLT gives res = 1, jump = 1, target = 0x120. BLTU gives res = 0, jump = 0.
- JALR: val1 = 0x1003, imm = 4, pc = 0x200 → res = 0x204, jump = 1, target = 0x1006.
- Flush: issue ops at k and k+1, assert flush at k+1 → no alu_valid at k+2 or k+3. An op issued at k+2 appears at k+4.
- rdy stall: result valid with tag 9, drop rdy for 3 cycles → outputs hold (valid = 1, tag 9). Raise rdy → pipeline resumes with no duplicate or lost op. Async reset asserted during the stall → outputs 0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, default widths and opcode class helpers shared by the
// execution unit, reservation station and ROB.
package alu_pkg;

    localparam int ROB_W_DEF = 6;
    localparam int XLEN_DEF  = 32;

    localparam logic [5:0] OP_NOP   = 6'd0,  OP_LUI   = 6'd1,  OP_AUIPC = 6'd2,
                           OP_JAL   = 6'd3,  OP_JALR  = 6'd4,
                           OP_BEQ   = 6'd5,  OP_BNE   = 6'd6,  OP_BLT   = 6'd7,
                           OP_BGE   = 6'd8,  OP_BLTU  = 6'd9,  OP_BGEU  = 6'd10,
                           OP_LB    = 6'd11, OP_LH    = 6'd12, OP_LW    = 6'd13,
                           OP_LBU   = 6'd14, OP_LHU   = 6'd15, OP_SB    = 6'd16,
                           OP_SH    = 6'd17, OP_SW    = 6'd18,
                           OP_ADDI  = 6'd19, OP_SLTI  = 6'd20, OP_SLTIU = 6'd21,
                           OP_XORI  = 6'd22, OP_ORI   = 6'd23, OP_ANDI  = 6'd24,
                           OP_SLLI  = 6'd25, OP_SRLI  = 6'd26, OP_SRAI  = 6'd27,
                           OP_ADD   = 6'd28, OP_SUB   = 6'd29, OP_SLL   = 6'd30,
                           OP_SLT   = 6'd31, OP_SLTU  = 6'd32, OP_XOR   = 6'd33,
                           OP_SRL   = 6'd34, OP_SRA   = 6'd35, OP_OR    = 6'd36,
                           OP_AND   = 6'd37;

    function automatic logic is_branch(input logic [5:0] op);
        return op >= OP_BEQ && op <= OP_BGEU;
    endfunction

    function automatic logic is_imm_type(input logic [5:0] op);
        return op >= OP_ADDI && op <= OP_SRAI;
    endfunction

    function automatic logic is_lsb_op(input logic [5:0] op);
        return op >= OP_LB && op <= OP_SW;
    endfunction

    // Memory ops never reach this unit, so they are treated as bubbles too.
    function automatic logic is_alu_op(input logic [5:0] op);
        return op != OP_NOP && op <= OP_AND && !is_lsb_op(op);
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational RV32I result and branch/jump decision from the
// E1 operands.
module alu_core import alu_pkg::*; #(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [5:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] res_o,
    output logic            jump_o
);

    logic [4:0] sh;
    logic       eq, lt, ltu;

    assign sh  = b_i[4:0];
    assign eq  = a_i == b_i;
    assign lt  = $signed(a_i) < $signed(b_i);
    assign ltu = a_i < b_i;

    always_comb begin
        res_o  = '0;
        jump_o = 1'b0;
        case (op_i)
            OP_LUI:            res_o = b_i;
            OP_AUIPC:          res_o = a_i + b_i;
            OP_JAL, OP_JALR:   begin res_o = pc_i + XLEN'(4); jump_o = 1'b1; end
            OP_BEQ:            begin res_o = XLEN'(eq);   jump_o = eq;   end
            OP_BNE:            begin res_o = XLEN'(!eq);  jump_o = !eq;  end
            OP_BLT:            begin res_o = XLEN'(lt);   jump_o = lt;   end
            OP_BGE:            begin res_o = XLEN'(!lt);  jump_o = !lt;  end
            OP_BLTU:           begin res_o = XLEN'(ltu);  jump_o = ltu;  end
            OP_BGEU:           begin res_o = XLEN'(!ltu); jump_o = !ltu; end
            OP_ADDI, OP_ADD:   res_o = a_i + b_i;
            OP_SUB:            res_o = a_i - b_i;
            OP_SLTI, OP_SLT:   res_o = XLEN'(lt);
            OP_SLTIU, OP_SLTU: res_o = XLEN'(ltu);
            OP_XORI, OP_XOR:   res_o = a_i ^ b_i;
            OP_ORI, OP_OR:     res_o = a_i | b_i;
            OP_ANDI, OP_AND:   res_o = a_i & b_i;
            OP_SLLI, OP_SLL:   res_o = a_i << sh;
            OP_SRLI, OP_SRL:   res_o = a_i >> sh;
            OP_SRAI, OP_SRA:   res_o = $unsigned($signed(a_i) >>> sh);
            default:           ;
        endcase
    end

endmodule

// File: rtl/alu.sv
// alu: two-stage pipelined integer execution unit; E1 selects operands and the
// control-transfer target, E2 computes and registers the broadcast result.
module alu import alu_pkg::*; #(
    parameter int ROB_W = ROB_W_DEF,
    parameter int XLEN  = XLEN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             flush,
    input  logic [5:0]       alu_opcode,
    input  logic [XLEN-1:0]  alu_val1,
    input  logic [XLEN-1:0]  alu_val2,
    input  logic [XLEN-1:0]  alu_imm,
    input  logic [XLEN-1:0]  alu_pc,
    input  logic [ROB_W-1:0] alu_rob_index,
    output logic             alu_valid,
    output logic [XLEN-1:0]  alu_res,
    output logic [ROB_W-1:0] alu_rob_index_out,
    output logic             alu_jump,
    output logic [XLEN-1:0]  alu_target
);

    logic             in_ok, use_pc, use_imm;
    logic             v1_d, v1_q, valid_d, valid_q, jump_d, jump_q, core_jump;
    logic [5:0]       op_d, op_q;
    logic [ROB_W-1:0] rob1_d, rob1_q, rob_d, rob_q;
    logic [XLEN-1:0]  a_d, a_q, b_d, b_q, pc_d, pc_q, tgt1_d, tgt1_q;
    logic [XLEN-1:0]  res_d, res_q, tgt_d, tgt_q, core_res;

    // Bubbles enter E1 with a zeroed payload so nothing stale propagates.
    always_comb begin
        in_ok   = is_alu_op(alu_opcode);
        use_pc  = alu_opcode == OP_AUIPC || alu_opcode == OP_JAL;
        use_imm = is_imm_type(alu_opcode) || alu_opcode == OP_LUI || alu_opcode == OP_AUIPC || alu_opcode == OP_JALR;
        v1_d    = in_ok;
        op_d    = in_ok ? alu_opcode : OP_NOP;
        rob1_d  = in_ok ? alu_rob_index : '0;
        pc_d    = in_ok ? alu_pc : '0;
        a_d     = !in_ok ? '0 : use_pc ? alu_pc : alu_val1;
        b_d     = !in_ok ? '0 : use_imm ? alu_imm : alu_val2;
        tgt1_d  = !in_ok ? '0
                : alu_opcode == OP_JALR ? (alu_val1 + alu_imm) & ~XLEN'(1)
                : (alu_opcode == OP_JAL || is_branch(alu_opcode)) ? alu_pc + alu_imm : '0;
    end

    alu_core #(.XLEN(XLEN)) u_core (
        .op_i   (op_q),
        .a_i    (a_q),
        .b_i    (b_q),
        .pc_i   (pc_q),
        .res_o  (core_res),
        .jump_o (core_jump)
    );

    always_comb begin
        valid_d = v1_q;
        res_d   = v1_q ? core_res : '0;
        rob_d   = v1_q ? rob1_q : '0;
        jump_d  = v1_q && core_jump;
        tgt_d   = (v1_q && core_jump) ? tgt1_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            op_q    <= OP_NOP;
            rob1_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            pc_q    <= '0;
            tgt1_q  <= '0;
            valid_q <= 1'b0;
            res_q   <= '0;
            rob_q   <= '0;
            jump_q  <= 1'b0;
            tgt_q   <= '0;
        end else if (rdy) begin
            v1_q    <= flush ? 1'b0 : v1_d;
            op_q    <= flush ? OP_NOP : op_d;
            rob1_q  <= flush ? '0 : rob1_d;
            a_q     <= flush ? '0 : a_d;
            b_q     <= flush ? '0 : b_d;
            pc_q    <= flush ? '0 : pc_d;
            tgt1_q  <= flush ? '0 : tgt1_d;
            valid_q <= flush ? 1'b0 : valid_d;
            res_q   <= flush ? '0 : res_d;
            rob_q   <= flush ? '0 : rob_d;
            jump_q  <= flush ? 1'b0 : jump_d;
            tgt_q   <= flush ? '0 : tgt_d;
        end
    end

    assign alu_valid         = valid_q;
    assign alu_res           = res_q;
    assign alu_rob_index_out = rob_q;
    assign alu_jump          = jump_q;
    assign alu_target        = tgt_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: randomized scoreboard bench for the alu with directed reset, flush
// and stall scenarios.
module tb_alu;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [31:0] tgt;
        logic        jump;
        logic [5:0]  rob;
        int          due;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, flush = 1'b0;
    logic [5:0]  alu_opcode = '0, alu_rob_index = '0;
    logic [31:0] alu_val1 = '0, alu_val2 = '0, alu_imm = '0, alu_pc = '0;
    logic        alu_valid, alu_jump;
    logic [31:0] alu_res, alu_target;
    logic [5:0]  alu_rob_index_out;

    exp_t sb[$];
    int   cyc = 0, n_cmp = 0, n_err = 0;
    logic fresh = 1'b0;

    always #5 clk = ~clk;

    alu dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rdy               (rdy),
        .flush             (flush),
        .alu_opcode        (alu_opcode),
        .alu_val1          (alu_val1),
        .alu_val2          (alu_val2),
        .alu_imm           (alu_imm),
        .alu_pc            (alu_pc),
        .alu_rob_index     (alu_rob_index),
        .alu_valid         (alu_valid),
        .alu_res           (alu_res),
        .alu_rob_index_out (alu_rob_index_out),
        .alu_jump          (alu_jump),
        .alu_target        (alu_target)
    );

    // cyc counts edges that actually advance the pipeline
    always @(posedge clk) begin
        fresh <= rst_n && rdy;
        if (rst_n && rdy) cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model(input logic [5:0] op, input logic [31:0] v1, v2, imm, pc,
                                  output logic ok, output logic [31:0] res,
                                  output logic jmp, output logic [31:0] tgt);
        logic tk;
        ok = 1'b1; jmp = 1'b0; tgt = pc + imm; res = '0; tk = 1'b0;
        case (op)
            OP_LUI:   res = imm;
            OP_AUIPC: res = pc + imm;
            OP_JAL:   begin res = pc + 4; jmp = 1'b1; end
            OP_JALR:  begin res = pc + 4; jmp = 1'b1; tgt = (v1 + imm) & 32'hFFFF_FFFE; end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                case (op)
                    OP_BEQ:  tk = v1 == v2;
                    OP_BNE:  tk = v1 != v2;
                    OP_BLT:  tk = $signed(v1) < $signed(v2);
                    OP_BGE:  tk = $signed(v1) >= $signed(v2);
                    OP_BLTU: tk = v1 < v2;
                    default: tk = v1 >= v2;
                endcase
                res = {31'b0, tk};
                jmp = tk;
            end
            OP_ADDI:  res = v1 + imm;
            OP_SLTI:  res = ($signed(v1) < $signed(imm)) ? 32'd1 : 32'd0;
            OP_SLTIU: res = (v1 < imm) ? 32'd1 : 32'd0;
            OP_XORI:  res = v1 ^ imm;
            OP_ORI:   res = v1 | imm;
            OP_ANDI:  res = v1 & imm;
            OP_SLLI:  res = v1 << imm[4:0];
            OP_SRLI:  res = v1 >> imm[4:0];
            OP_SRAI:  res = $unsigned($signed(v1) >>> imm[4:0]);
            OP_ADD:   res = v1 + v2;
            OP_SUB:   res = v1 - v2;
            OP_SLL:   res = v1 << v2[4:0];
            OP_SLT:   res = ($signed(v1) < $signed(v2)) ? 32'd1 : 32'd0;
            OP_SLTU:  res = (v1 < v2) ? 32'd1 : 32'd0;
            OP_XOR:   res = v1 ^ v2;
            OP_SRL:   res = v1 >> v2[4:0];
            OP_SRA:   res = $unsigned($signed(v1) >>> v2[4:0]);
            OP_OR:    res = v1 | v2;
            OP_AND:   res = v1 & v2;
            default:  ok = 1'b0;
        endcase
    endfunction

    task automatic issue(input logic [5:0] op, input logic [31:0] v1, v2, imm, pc,
                         input logic [5:0] tag, input logic fl, input logic r);
        exp_t        e;
        logic        ok, jmp;
        logic [31:0] res, tgt;
        @(negedge clk);
        alu_opcode = op; alu_val1 = v1; alu_val2 = v2; alu_imm = imm; alu_pc = pc;
        alu_rob_index = tag; flush = fl; rdy = r;
        model(op, v1, v2, imm, pc, ok, res, jmp, tgt);
        e.res = res; e.tgt = tgt; e.jump = jmp; e.rob = tag; e.due = cyc + 2;
        // a flush kills everything not yet on the output registers
        if (r && fl)
            while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
        if (r && !fl && ok) sb.push_back(e);
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) issue(OP_NOP, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && fresh) begin
            if (alu_valid) begin
                if (sb.size() == 0) chk("unexpected_valid", {31'b0, alu_valid}, 32'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", cyc, e.due);
                    chk("res", alu_res, e.res);
                    chk("rob_tag", {26'b0, alu_rob_index_out}, {26'b0, e.rob});
                    chk("jump", {31'b0, alu_jump}, {31'b0, e.jump});
                    if (e.jump) chk("target", alu_target, e.tgt);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                chk("missing_valid", {31'b0, alu_valid}, 32'd1);
                void'(sb.pop_front());
            end else begin
                chk("idle_res", alu_res, 32'd0);
                chk("idle_jump", {31'b0, alu_jump}, 32'd0);
                chk("idle_target", alu_target, 32'd0);
            end
        end
    end

    task automatic stall_hold(input logic [31:0] exp_res);
        @(negedge clk);
        rdy = 1'b0; alu_opcode = OP_NOP;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'b0, alu_valid}, 32'd1);
            chk("stall_tag", {26'b0, alu_rob_index_out}, 32'd9);
            chk("stall_res", alu_res, exp_res);
        end
    endtask

    task automatic random_phase(input int n);
        logic [5:0] op;
        for (int i = 0; i < n; i++) begin
            op = 6'($urandom_range(0, 40));
            issue(op, rnd32(), rnd32(), rnd32(), $urandom() & 32'hFFFF_FFFC, 6'($urandom()),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 7) != 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'b0, alu_valid}, 32'd0);
        chk("rst_res", alu_res, 32'd0);
        chk("rst_tag", {26'b0, alu_rob_index_out}, 32'd0);
        chk("rst_jump", {31'b0, alu_jump}, 32'd0);
        chk("rst_target", alu_target, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bubbles(5);

        issue(OP_ADD, 7, 5, 0, 0, 3, 1'b0, 1'b1);
        issue(OP_SUB, 7, 5, 0, 0, 4, 1'b0, 1'b1);
        issue(OP_SUB, 0, 1, 0, 0, 5, 1'b0, 1'b1);
        issue(OP_BLT, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 6, 1'b0, 1'b1);
        issue(OP_BLTU, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 7, 1'b0, 1'b1);
        issue(OP_JALR, 32'h1003, 0, 4, 32'h200, 8, 1'b0, 1'b1);
        issue(OP_SRAI, 32'h8000_0000, 0, 32'hFFFF_FFE4, 0, 10, 1'b0, 1'b1);
        issue(OP_LW, 1, 2, 3, 4, 11, 1'b0, 1'b1);
        bubbles(3);

        issue(OP_ADD, 1, 1, 0, 0, 20, 1'b0, 1'b1);
        issue(OP_ADD, 2, 2, 0, 0, 21, 1'b1, 1'b1);
        issue(OP_ADD, 3, 3, 0, 0, 22, 1'b0, 1'b1);
        bubbles(3);

        issue(OP_ADDI, 100, 0, 23, 0, 9, 1'b0, 1'b1);
        issue(OP_XOR, 32'hF0, 32'h0F, 0, 0, 12, 1'b1, 1'b0);
        issue(OP_ADD, 1, 2, 0, 0, 13, 1'b0, 1'b1);
        stall_hold(32'd123);
        rdy = 1'b1;
        bubbles(3);

        issue(OP_ADDI, 100, 0, 23, 0, 9, 1'b0, 1'b1);
        issue(OP_ADD, 1, 2, 0, 0, 14, 1'b0, 1'b1);
        stall_hold(32'd123);
        #2 rst_n = 1'b0;
        flush = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, alu_valid}, 32'd0);
        chk("async_rst_res", alu_res, 32'd0);
        chk("async_rst_tag", {26'b0, alu_rob_index_out}, 32'd0);
        chk("async_rst_jump", {31'b0, alu_jump}, 32'd0);
        chk("async_rst_target", alu_target, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1; rdy = 1'b1; flush = 1'b0;
        bubbles(4);

        random_phase(600);
        bubbles(4);
        chk("drain_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
